// File: rtl/c1_bus_responder.sv
// c1_bus_responder: memory-side slave of the C1 command bus with a small aliased byte store.
// Optional feature macro: C1_INV_LINE_EN (accept INV_LINE as a data-less single-beat transaction).
module c1_bus_responder #(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned BUS_SIZE          = 16,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned STORE_ADDR_SIZE   = 10,
  parameter int unsigned RESP_DELAY        = 2
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                        data,
  inout  wire  [2:0]                                 command,
  output logic                                       busy
);

  localparam int unsigned TAG_W       = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int unsigned STORE_BYTES = 1 << STORE_ADDR_SIZE;
  localparam int unsigned STORE_BITS  = STORE_BYTES * 8;
  localparam int unsigned CNT_W       = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  localparam logic [2:0] CMD_READ8    = 3'd1;
  localparam logic [2:0] CMD_READ16   = 3'd2;
  localparam logic [2:0] CMD_READ32   = 3'd3;
`ifdef C1_INV_LINE_EN
  localparam logic [2:0] CMD_INV_LINE = 3'd4;
`endif
  localparam logic [2:0] CMD_WRITE8   = 3'd5;
  localparam logic [2:0] CMD_WRITE16  = 3'd6;
  localparam logic [2:0] CMD_WRITE32  = 3'd7;
  localparam logic [2:0] CMD_RESP     = 3'd7;

  // Power-on store contents: byte[i] = i[7:0].
  function automatic logic [STORE_BITS-1:0] store_init();
    logic [STORE_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(STORE_BYTES); i++) v[i*8 +: 8] = 8'(i);
    return v;
  endfunction

  localparam logic [STORE_BITS-1:0] STORE_INIT = store_init();

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_TURN,
    S_WAIT,
    S_RESP0,
    S_RESP1
  } state_e;

  state_e                       state_q, state_next;
  logic [2:0]                   cmd_q, cmd_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic [CACHE_OFFSET_SIZE-1:0] off_q, off_d;
  logic [BUS_SIZE-1:0]          lo_q, lo_d;
  logic [BUS_SIZE-1:0]          hi_q, hi_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic                         cmd_oe_q, cmd_oe_d;
  logic                         data_oe_q, data_oe_d;
  logic [BUS_SIZE-1:0]          dout_q, dout_d;
  logic [STORE_BITS-1:0]        mem_q;

  logic [STORE_ADDR_SIZE-1:0]   byte_addr;
  logic [STORE_ADDR_SIZE-3:0]   word_addr;
  logic [7:0]                   rb, q0, q1, q2, q3;
  logic                         accept;
  logic                         enter_resp;
  logic                         beat0_oe;
  logic [BUS_SIZE-1:0]          beat0;

  // Byte address aliases onto the store by dropping the high address bits.
  assign byte_addr = STORE_ADDR_SIZE'({tag_q, off_q});
  assign word_addr = byte_addr[STORE_ADDR_SIZE-1:2];

  assign rb = mem_q[{byte_addr, 3'b000} +: 8];
  assign q0 = mem_q[{word_addr, 2'd0, 3'b000} +: 8];
  assign q1 = mem_q[{word_addr, 2'd1, 3'b000} +: 8];
  assign q2 = mem_q[{word_addr, 2'd2, 3'b000} +: 8];
  assign q3 = mem_q[{word_addr, 2'd3, 3'b000} +: 8];

  assign command = cmd_oe_q  ? CMD_RESP : 3'bzzz;
  assign data    = data_oe_q ? dout_q   : {BUS_SIZE{1'bz}};
  assign busy    = busy_q;

  // Commands that open a transaction from IDLE; anything else (incl. X/Z) is ignored.
  always_comb begin
    accept = 1'b0;
    case (command)
      CMD_READ8, CMD_READ16, CMD_READ32,
      CMD_WRITE8, CMD_WRITE16, CMD_WRITE32: accept = 1'b1;
`ifdef C1_INV_LINE_EN
      CMD_INV_LINE:                         accept = 1'b1;
`endif
      default:                              accept = 1'b0;
    endcase
  end

  // First response beat; reads are aligned to their access size.
  always_comb begin
    beat0    = '0;
    beat0_oe = 1'b0;
    case (cmd_q)
      CMD_READ8: begin
        beat0    = {8'h00, rb};
        beat0_oe = 1'b1;
      end
      CMD_READ16: begin
        beat0    = byte_addr[1] ? {q3, q2} : {q1, q0};
        beat0_oe = 1'b1;
      end
      CMD_READ32: begin
        beat0    = {q1, q0};
        beat0_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    off_d      = off_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    cmd_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    dout_d     = dout_q;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d      = command;
          tag_d      = address;
          lo_d       = data;
          busy_d     = 1'b1;
          state_next = S_ADDR2;
        end
      end
      S_ADDR2: begin
        off_d = address[CACHE_OFFSET_SIZE-1:0];
        if (cmd_q == CMD_WRITE32) hi_d = data;
        state_next = S_TURN;
      end
      S_TURN: begin
        if (RESP_DELAY == 0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d      = CNT_W'(RESP_DELAY - 1);
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) enter_resp = 1'b1;
        else             cnt_d      = cnt_q - CNT_W'(1);
      end
      S_RESP0: begin
        if (cmd_q == CMD_READ32) begin
          cmd_oe_d   = 1'b1;
          data_oe_d  = 1'b1;
          dout_d     = {q3, q2};
          state_next = S_RESP1;
        end else begin
          busy_d     = 1'b0;
          state_next = S_IDLE;
        end
      end
      S_RESP1: begin
        busy_d     = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (enter_resp) begin
      cmd_oe_d   = 1'b1;
      data_oe_d  = beat0_oe;
      dout_d     = beat0;
      state_next = S_RESP0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      tag_q     <= '0;
      off_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      cmd_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_next;
      cmd_q     <= cmd_d;
      tag_q     <= tag_d;
      off_q     <= off_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      cmd_oe_q  <= cmd_oe_d;
      data_oe_q <= data_oe_d;
      dout_q    <= dout_d;
    end
  end

  // Store writes land during the turnaround cycle, little-endian and size-aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= STORE_INIT;
    end else if (state_q == S_TURN) begin
      case (cmd_q)
        CMD_WRITE8: mem_q[{byte_addr, 3'b000} +: 8] <= lo_q[7:0];
        CMD_WRITE16: begin
          mem_q[{word_addr, byte_addr[1], 1'b0, 3'b000} +: 8] <= lo_q[7:0];
          mem_q[{word_addr, byte_addr[1], 1'b1, 3'b000} +: 8] <= lo_q[15:8];
        end
        CMD_WRITE32: begin
          mem_q[{word_addr, 2'd0, 3'b000} +: 8] <= lo_q[7:0];
          mem_q[{word_addr, 2'd1, 3'b000} +: 8] <= lo_q[15:8];
          mem_q[{word_addr, 2'd2, 3'b000} +: 8] <= hi_q[7:0];
          mem_q[{word_addr, 2'd3, 3'b000} +: 8] <= hi_q[15:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c1_bus_responder.sv
// tb_c1_bus_responder: scoreboard bench for c1_bus_responder (default parameters, RESP_DELAY=2).
// Released bus lines resolve through pulls: command reads 0, data reads 16'hFFFF.
module tb_c1_bus_responder;

  localparam logic [2:0] C_READ8   = 3'd1;
  localparam logic [2:0] C_READ16  = 3'd2;
  localparam logic [2:0] C_READ32  = 3'd3;
  localparam logic [2:0] C_INV     = 3'd4;
  localparam logic [2:0] C_WRITE8  = 3'd5;
  localparam logic [2:0] C_WRITE16 = 3'd6;
  localparam logic [2:0] C_WRITE32 = 3'd7;
  localparam logic [15:0] REL_DATA = 16'hFFFF;
  localparam logic [2:0]  REL_CMD  = 3'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] address = '0;
  wire  [15:0] data;
  wire  [2:0]  command;
  logic        busy;

  logic [15:0] tb_data = '0;
  logic        tb_data_en = 1'b0;
  logic [2:0]  tb_cmd = '0;
  logic        tb_cmd_en = 1'b0;

  assign data    = tb_data_en ? tb_data : 16'hzzzz;
  assign command = tb_cmd_en  ? tb_cmd  : 3'bzzz;
  pullup   (data);
  pulldown (command);

  int checks = 0;
  int errors = 0;
  logic [7:0]  model [1024];
  logic [15:0] exp_q [$];

  c1_bus_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .address (address),
    .data    (data),
    .command (command),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) model[i] = 8'(i);
    exp_q.delete();
  endtask

  // Drive cycle A and cycle B; the model updates and pushes the expected beats.
  task automatic start_txn(input logic [2:0] cmd, input logic [14:0] tag,
                           input logic [3:0] off, input logic [15:0] lo, input logic [15:0] hi);
    logic [9:0] ba;
    ba = 10'({tag, off});
    case (cmd)
      C_READ8:  exp_q.push_back({8'h00, model[ba]});
      C_READ16: exp_q.push_back({model[{ba[9:1], 1'b1}], model[{ba[9:1], 1'b0}]});
      C_READ32: begin
        exp_q.push_back({model[{ba[9:2], 2'd1}], model[{ba[9:2], 2'd0}]});
        exp_q.push_back({model[{ba[9:2], 2'd3}], model[{ba[9:2], 2'd2}]});
      end
      C_WRITE8: begin
        model[ba] = lo[7:0];
        exp_q.push_back(REL_DATA);
      end
      C_WRITE16: begin
        model[{ba[9:1], 1'b0}] = lo[7:0];
        model[{ba[9:1], 1'b1}] = lo[15:8];
        exp_q.push_back(REL_DATA);
      end
      C_WRITE32: begin
        model[{ba[9:2], 2'd0}] = lo[7:0];
        model[{ba[9:2], 2'd1}] = lo[15:8];
        model[{ba[9:2], 2'd2}] = hi[7:0];
        model[{ba[9:2], 2'd3}] = hi[15:8];
        exp_q.push_back(REL_DATA);
      end
      default: exp_q.push_back(REL_DATA);
    endcase
    @(negedge clk);
    address    = tag;
    tb_cmd     = cmd;
    tb_cmd_en  = 1'b1;
    tb_data    = lo;
    tb_data_en = (cmd == C_WRITE8) || (cmd == C_WRITE16) || (cmd == C_WRITE32);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_cycle_a: got %b expected 1", busy);
    end
    @(negedge clk);
    tb_cmd_en  = 1'b0;
    address    = 15'(off);
    tb_data    = hi;
    tb_data_en = (cmd == C_WRITE32);
    @(negedge clk);
    tb_data_en = 1'b0;
  endtask

  // Wait for the response, compare every beat, then check the bus release.
  task automatic finish_txn(input string name);
    int n;
    bit found;
    logic [15:0] exp;
    n = 1;
    found = 1'b0;
    while (n < 12 && !found) begin
      @(posedge clk); #1;
      n++;
      if (command === 3'd7) found = 1'b1;
    end
    checks++;
    if (!found || n != 4) begin
      errors++;
      $display("FAIL %s_latency: got edge A+%0d (found=%0d) expected A+4", name, n, found);
    end
    if (found) begin
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (command !== 3'd7 || data !== exp) begin
          errors++;
          $display("FAIL %s_beat: got cmd=%h data=%h expected cmd=7 data=%h", name, command, data, exp);
        end
        @(posedge clk); #1;
      end
    end
    exp_q.delete();
    checks++;
    if (command !== REL_CMD || data !== REL_DATA || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got cmd=%h data=%h busy=%b expected released, busy=0",
               name, command, data, busy);
    end
  endtask

  task automatic run_txn(input string name, input logic [2:0] cmd, input logic [14:0] tag,
                         input logic [3:0] off, input logic [15:0] lo, input logic [15:0] hi);
    start_txn(cmd, tag, off, lo, hi);
    finish_txn(name);
  endtask

  task automatic check_released(input string name);
    checks++;
    if (command !== REL_CMD || data !== REL_DATA || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got cmd=%h data=%h busy=%b expected released, busy=0",
               name, command, data, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_released("reset_state");
    reset_n = 1'b1;
  endtask

  task automatic test_read8();
    run_txn("read8_addr2", C_READ8, 15'd0, 4'd2, 16'h0, 16'h0);
  endtask

  task automatic test_write8();
    run_txn("write8_addr2", C_WRITE8, 15'd0, 4'd2, 16'h5555, 16'h0);
    run_txn("read8_after_write", C_READ8, 15'd0, 4'd2, 16'h0, 16'h0);
    run_txn("read8_addr3", C_READ8, 15'd0, 4'd3, 16'h0, 16'h0);
  endtask

  task automatic test_read16_32();
    run_txn("read16_aligned", C_READ16, 15'd1, 4'd3, 16'h0, 16'h0);
    run_txn("read32_aligned", C_READ32, 15'd3, 4'd6, 16'h0, 16'h0);
  endtask

  task automatic test_write32_alias();
    run_txn("write32", C_WRITE32, 15'd2, 4'd0, 16'hBEEF, 16'hDEAD);
    run_txn("read32_back", C_READ32, 15'd2, 4'd0, 16'h0, 16'h0);
    run_txn("read32_alias", C_READ32, 15'd66, 4'd0, 16'h0, 16'h0);
    run_txn("write16_unaligned", C_WRITE16, 15'd5, 4'd7, 16'hA1B2, 16'h0);
    run_txn("read16_back", C_READ16, 15'd5, 4'd6, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    // Reset during WAIT.
    start_txn(C_READ8, 15'd0, 4'd2, 16'h0, 16'h0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_wait: got %b expected 1", busy);
    end
    #1 reset_n = 1'b0;
    #1 check_released("reset_in_wait");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    // Reset during READ32 beat 1.
    start_txn(C_READ32, 15'd3, 4'd6, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (command !== 3'd7 || data !== exp) begin
      errors++;
      $display("FAIL reset_mid_beat0: got cmd=%h data=%h expected cmd=7 data=%h", command, data, exp);
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    checks++;
    if (command !== 3'd7 || data !== exp) begin
      errors++;
      $display("FAIL reset_mid_beat1: got cmd=%h data=%h expected cmd=7 data=%h", command, data, exp);
    end
    #1 reset_n = 1'b0;
    #1 check_released("reset_in_beat1");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("read8_after_reset", C_READ8, 15'd0, 4'd2, 16'h0, 16'h0);
  endtask

  task automatic test_inv_line();
`ifdef C1_INV_LINE_EN
    run_txn("inv_line", C_INV, 15'd0, 4'd0, 16'h0, 16'h0);
`else
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    address   = 15'd0;
    tb_cmd    = C_INV;
    tb_cmd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || (i > 0 && command === 3'd7)) seen = 1'b1;
      if (i == 0) tb_cmd_en = 1'b0;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL inv_line_ignored: got busy or response, expected none for 8 cycles");
    end
`endif
    run_txn("read32_after_inv", C_READ32, 15'd0, 4'd0, 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] cmd;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 4))
        0:       cmd = C_READ8;
        1:       cmd = C_READ16;
        2:       cmd = C_READ32;
        3:       cmd = C_WRITE8;
        default: cmd = C_WRITE32;
      endcase
      if (i % 4 == 1) cmd = C_WRITE16;
      run_txn("random", cmd, 15'($urandom_range(0, 127)), 4'($urandom),
              16'($urandom) & 16'h7F7F, 16'($urandom) & 16'h7F7F);
    end
  endtask

  initial begin
    test_reset();
    test_read8();
    test_write8();
    test_read16_32();
    test_write32_alias();
    test_reset_mid();
    test_inv_line();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
